multi_channel_accumulator: RTL

MULTI_CHANNEL_ACCUMULATOR -- requirements
Module: multi_channel_accumulator

---
 rtl/acc_pkg.sv | 28 ++
 rtl/acc_sat_add.sv | 38 +++
 rtl/multi_channel_accumulator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared defaults, channel-index width helper and signed limits for the
// multi-channel accumulator.
package acc_pkg;

    localparam int ACC_IL_DEFAULT  = 10;
    localparam int ACC_OL_DEFAULT  = 16;
    localparam int ACC_NCH_DEFAULT = 4;
    localparam int ACC_CW_DEFAULT  = 4;

    // Index width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic logic signed [63:0] acc_smax(input int ol);
        return (64'sd1 <<< (ol - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_smin(input int ol);
        return -(64'sd1 <<< (ol - 1));
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// OL-bit signed adder with overflow flag; clamps to the signed limits when
// ACC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int OL = ACC_OL_DEFAULT
) (
    input  logic signed [OL-1:0] a,
    input  logic signed [OL-1:0] b,
    output logic signed [OL-1:0] sum,
    output logic                 ovf
);

    logic signed [OL-1:0] raw;

    // Signed overflow: operands agree in sign but the result does not.
    always_comb begin
        raw = a + b;
        ovf = (a[OL-1] == b[OL-1]) && (raw[OL-1] != a[OL-1]);
    end

`ifdef ACC_SATURATE_EN
    localparam logic signed [63:0] MAX64 = acc_smax(OL);
    localparam logic signed [63:0] MIN64 = acc_smin(OL);
    localparam logic signed [OL-1:0] SAT_MAX = MAX64[OL-1:0];
    localparam logic signed [OL-1:0] SAT_MIN = MIN64[OL-1:0];

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[OL-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/multi_channel_accumulator.sv
// Per-channel sample accumulator with one shared adder and a single
// registered output stage; ACC_SATURATE_EN selects clamping instead of wrap.
module multi_channel_accumulator
    import acc_pkg::*;
#(
    parameter int IL  = ACC_IL_DEFAULT,
    parameter int OL  = ACC_OL_DEFAULT,
    parameter int NCH = ACC_NCH_DEFAULT,
    parameter int CW  = ACC_CW_DEFAULT
) (
    input  logic                           iCLK,
    input  logic                           iRSTn,
    input  logic                           iCLR,
    input  logic                           iEN,
    output logic                           oREADY,
    input  logic [clog2_min1(NCH)-1:0]     iCH,
    input  logic signed [IL-1:0]           iDATA,
    input  logic [CW-1:0]                  iLEN,
    output logic                           oEN,
    input  logic                           iREADY,
    output logic [clog2_min1(NCH)-1:0]     oCH,
    output logic signed [OL-1:0]           oDATA,
    output logic                           oOVF
);

    localparam int CHW = clog2_min1(NCH);

    logic signed [OL-1:0] sum_q [NCH];
    logic signed [OL-1:0] sum_d [NCH];
    logic [CW-1:0]        cnt_q [NCH];
    logic [CW-1:0]        cnt_d [NCH];
    logic [NCH-1:0]       ovf_q, ovf_d;

    logic                 oen_q, oen_d;
    logic [CHW-1:0]       och_q, och_d;
    logic signed [OL-1:0] odata_q, odata_d;
    logic                 oovf_q, oovf_d;

    logic                 accept, hit, dump;
    logic signed [OL-1:0] add_a, add_b, add_sum;
    logic                 add_ovf;
    logic [CW-1:0]        cur_cnt;
    logic                 cur_ovf;

    assign oREADY = !oen_q || iREADY;
    assign accept = iEN && oREADY;
    assign hit    = accept && (32'(iCH) < 32'(NCH));

    // A same-edge clear makes the incoming sample the first of its channel.
    always_comb begin
        add_a   = '0;
        cur_cnt = '0;
        cur_ovf = 1'b0;
        if (hit && !iCLR) begin
            add_a   = sum_q[iCH];
            cur_cnt = cnt_q[iCH];
            cur_ovf = ovf_q[iCH];
        end
    end

    assign add_b = OL'(iDATA);
    assign dump  = hit && (cur_cnt >= iLEN);

    acc_sat_add #(
        .OL (OL)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (iCLR) begin
            for (int i = 0; i < NCH; i++) begin
                sum_d[i] = '0;
                cnt_d[i] = '0;
            end
            ovf_d = '0;
        end
        if (hit) begin
            if (dump) begin
                sum_d[iCH] = '0;
                cnt_d[iCH] = '0;
                ovf_d[iCH] = 1'b0;
            end else begin
                sum_d[iCH] = add_sum;
                cnt_d[iCH] = cur_cnt + CW'(1);
                ovf_d[iCH] = cur_ovf | add_ovf;
            end
        end
    end

    // A new dump may replace an output that is handshaking on the same edge.
    always_comb begin
        oen_d   = oen_q;
        och_d   = och_q;
        odata_d = odata_q;
        oovf_d  = oovf_q;
        if (dump) begin
            oen_d   = 1'b1;
            och_d   = iCH;
            odata_d = add_sum;
            oovf_d  = cur_ovf | add_ovf;
        end else if (oen_q && iREADY) begin
            oen_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q   <= '0;
            oen_q   <= 1'b0;
            och_q   <= '0;
            odata_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            oen_q   <= oen_d;
            och_q   <= och_d;
            odata_q <= odata_d;
            oovf_q  <= oovf_d;
        end
    end

    assign oEN   = oen_q;
    assign oCH   = och_q;
    assign oDATA = odata_q;
    assign oOVF  = oovf_q;

endmodule
